// File: rtl/dmem_arb_pkg.sv
// Shared state encoding, requester IDs and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOAD   = 1'b1;
  localparam int   DEPTH_DEF  = 64;
  localparam int   ADDR_W_DEF = 32;

  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way grant selection between core and image loader.
// DMEM_ARB_RR_EN selects round-robin on contention; otherwise the core has fixed priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic c_req_i,
  input  logic l_req_i,
`ifdef DMEM_ARB_RR_EN
  input  logic last_i,
`endif
  output logic vld_o,
  output logic gnt_o
);

  assign vld_o = c_req_i | l_req_i;

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    gnt_o = REQ_CORE;
    if (c_req_i && l_req_i) begin
      gnt_o = (last_i == REQ_CORE) ? REQ_LOAD : REQ_CORE;
    end else if (l_req_i) begin
      gnt_o = REQ_LOAD;
    end
  end
`else
  assign gnt_o = c_req_i ? REQ_CORE : REQ_LOAD;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates core and loader access to a byte-wide data memory; words are written LSB first.
// Define DMEM_ARB_RR_EN for round-robin arbitration (default build: core has fixed priority).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic              c_word,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_ack,
  output logic              c_err,
  output logic [31:0]       c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic              l_word,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_ack,
  output logic              l_err,
  output logic [31:0]       l_rdata,
  output logic              mem_we_n,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_din,
  input  logic [31:0]       mem_do,
  output logic              busy
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              pick_vld, pick_gnt;
  logic              sel_we, sel_word;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [ADDR_W:0]   sel_end;

`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;

  dmem_arb_pick u_pick (
    .c_req_i (c_req),
    .l_req_i (l_req),
    .last_i  (last_q),
    .vld_o   (pick_vld),
    .gnt_o   (pick_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_LOAD;
    end else begin
      last_q <= last_d;
    end
  end
`else
  dmem_arb_pick u_pick (
    .c_req_i (c_req),
    .l_req_i (l_req),
    .vld_o   (pick_vld),
    .gnt_o   (pick_gnt)
  );
`endif

  assign sel_we    = (pick_gnt == REQ_LOAD) ? l_we    : c_we;
  assign sel_word  = (pick_gnt == REQ_LOAD) ? l_word  : c_word;
  assign sel_addr  = (pick_gnt == REQ_LOAD) ? l_addr  : c_addr;
  assign sel_wdata = (pick_gnt == REQ_LOAD) ? l_wdata : c_wdata;
  // One extra bit so an access straddling the top of the address space is still out of range.
  assign sel_end   = {1'b0, sel_addr} + {{(ADDR_W-1){1'b0}}, sel_word, sel_word};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef DMEM_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_gnt;
          we_d    = sel_we;
          word_d  = sel_word;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          cnt_d   = '0;
          err_d   = 1'b0;
          rdata_d = '0;
`ifdef DMEM_ARB_RR_EN
          last_d  = pick_gnt;
`endif
          if (sel_end >= LIMIT) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (sel_we) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        rdata_d = word_q ? mem_do : {24'h0, mem_do[7:0]};
        state_d = DONE;
      end
      WR: begin
        if (!word_q || cnt_q == 2'd3) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= REQ_CORE;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Latched request fields are only consumed after IDLE reloads them.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    word_q  <= word_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign busy    = (state_q != IDLE);
  assign c_ack   = (state_q == DONE) && (gnt_q == REQ_CORE);
  assign l_ack   = (state_q == DONE) && (gnt_q == REQ_LOAD);
  assign c_err   = c_ack & err_q;
  assign l_err   = l_ack & err_q;
  assign c_rdata = c_ack ? rdata_q : '0;
  assign l_rdata = l_ack ? rdata_q : '0;

  always_comb begin
    mem_we_n = 1'b1;
    mem_a    = '0;
    mem_din  = '0;
    case (state_q)
      RD: mem_a = addr_q;
      WR: begin
        mem_we_n = 1'b0;
        mem_a    = addr_q + ADDR_W'(cnt_q);
        mem_din  = byte_lane(wdata_q, cnt_q);
      end
      default: ;
    endcase
  end

endmodule
